fp_operand_collector: RTL

//  Upstream byte-to-operand stage for the FP32 adder/subtractor datapath.

---
 rtl/fp_operand_collector.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fp_operand_collector.sv
// Byte-to-operand collector feeding the FP32 add/sub datapath.
// Optional inter-byte timeout: define FP_COLLECT_TIMEOUT_EN.
module fp_operand_collector #(
  parameter int MSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        opcode_in,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_sub,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [2:0]  byte_cnt,
  output logic [1:0]  state_out,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD_A = 2'b01,
    LOAD_B = 2'b10,
    HOLD   = 2'b11
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t      state_q, state_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        op_sub_q, op_sub_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic        rdy_en_q, rdy_en_d;
  logic        accept;
  logic [1:0]  lane;

`ifdef FP_COLLECT_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] idle_q, idle_d;
  logic        timeout_err_q, timeout_err_d;
`endif

  // ready only comes up one edge after reset release
  assign rdy_en_d  = 1'b1;
  assign in_ready  = rdy_en_q && (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign lane      = (MSB_FIRST != 0) ? ~byte_cnt_q[1:0]
                                      : byte_cnt_q[1:0];
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_sub    = op_sub_q;
  assign op_valid  = (state_q == HOLD);
  assign byte_cnt  = byte_cnt_q;
  assign state_out = state_q;

  // next-state, byte placement and timeout logic
  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sub_d   = op_sub_q;
    byte_cnt_d = byte_cnt_q;
`ifdef FP_COLLECT_TIMEOUT_EN
    idle_d        = '0;
    timeout_err_d = 1'b0;
`endif
    if (abort) begin
      state_d    = IDLE;
      byte_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_a_d[{lane, 3'b000} +: 8] = in_data;
            op_sub_d   = opcode_in;
            byte_cnt_d = 3'd1;
            state_d    = LOAD_A;
          end
        end
        LOAD_A: begin
          if (accept) begin
            op_a_d[{lane, 3'b000} +: 8] = in_data;
            byte_cnt_d = byte_cnt_q + 3'd1;
            if (byte_cnt_q == 3'd3) state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (accept) begin
            op_b_d[{lane, 3'b000} +: 8] = in_data;
            if (byte_cnt_q == 3'd7) begin
              byte_cnt_d = '0;
              state_d    = HOLD;
            end else begin
              byte_cnt_d = byte_cnt_q + 3'd1;
            end
          end
        end
        HOLD: begin
          if (op_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
`ifdef FP_COLLECT_TIMEOUT_EN
      if ((state_q == LOAD_A || state_q == LOAD_B) && !accept) begin
        if (idle_q == TO_LAST) begin
          state_d       = IDLE;
          byte_cnt_d    = '0;
          timeout_err_d = 1'b1;
        end else begin
          idle_d = idle_q + 16'd1;
        end
      end
`endif
    end
  end

  // main state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_sub_q   <= 1'b0;
      byte_cnt_q <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sub_q   <= op_sub_d;
      byte_cnt_q <= byte_cnt_d;
      rdy_en_q   <= rdy_en_d;
    end
  end

`ifdef FP_COLLECT_TIMEOUT_EN
  // idle counter and one-cycle timeout pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      idle_q        <= idle_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
